// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared 32-bit memory port: instruction fetch (0) vs data access (1).
// Sequences each access IDLE -> BUSY -> RESP and aborts hung accesses after TIMEOUT busy cycles.
//
// state | meaning
// IDLE  | no owner; requests sampled, winner chosen round-robin
// BUSY  | winner drives the memory port, waiting for mem_ready or timeout
// RESP  | done pulse to the winner, gnt still held, memory idle
module mem_port_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic        last;
    logic [7:0]  count;
    logic        winner;
    logic        sel_we;
    logic        timed_out;

    // On a tie the requester that did not win last time gets the port.
    assign winner    = (req0 && req1) ? ~last : req1;
    assign sel_we    = sel ? we1 : we0;
    assign timed_out = (count == COUNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req0 || req1) next_state = BUSY;
            BUSY:    if (mem_ready || timed_out) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel   <= 1'b0;
            last  <= 1'b1;
            count <= 8'd0;
            rdata <= 32'd0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        sel   <= winner;
                        last  <= winner;
                        count <= 8'd0;
                    end
                end
                BUSY: begin
                    // mem_ready takes priority over an expiring timeout
                    if (mem_ready) begin
                        rdata <= sel_we ? 32'd0 : mem_rdata;
                        err   <= 1'b0;
                    end else if (timed_out) begin
                        rdata <= 32'd0;
                        err   <= 1'b1;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt0      = (state != IDLE) && !sel;
        gnt1      = (state != IDLE) &&  sel;
        done0     = (state == RESP) && !sel;
        done1     = (state == RESP) &&  sel;
        mem_valid = (state == BUSY);
    end

    assign mem_addr  = sel ? addr1 : addr0;
    assign mem_wdata = sel ? wdata1 : wdata0;
    assign mem_we    = mem_valid & sel_we;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester, round-robin arbiter for the single shared 32-bit memory port. Instruction fetch is requester 0 and data access is requester 1. The block drives the select of the shared 32-bit input mux (op=0 passes requester 0, op=1 passes requester 1) and sequences each access through a request/ready handshake. It returns read data and a completion pulse to the winner, and aborts hung accesses with a bounded timeout.

## Interface
- TIMEOUT, 15: maximum BUSY cycles without mem_ready before abort; legal range 2..255.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on clk rising edge.
- req0, req1  input  1  access request per requester; level, held until done.
- addr0, addr1  input  32  access address; stable while corresponding gnt high.
- wdata0, wdata1  input  32  write data; stable while corresponding gnt high.
- we0, we1  input  1  1 = write, 0 = read; stable while gnt high.
- gnt0, gnt1  output  1  requester owns the port (high in BUSY and RESP).
- done0, done1  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 = access aborted by timeout.
- rdata  output  32  registered read data; valid with done, held until next done.
- sel  output  1  mux select: 0 = requester 0 inputs, 1 = requester 1 inputs.
- mem_valid  output  1  access request to memory.
- mem_addr, mem_wdata  output  32  muxed from requester selected by sel.
- mem_we  output  1  muxed we, gated by mem_valid.
- mem_rdata  input  32  memory read data, valid when mem_ready.
- mem_ready  input  1  memory accepts/completes access this cycle.

## Operation
- FSM states: IDLE, BUSY, RESP. A last-grant register `last` (1 bit) holds the most recently granted requester.
- IDLE: if no req, stay. If exactly one req, grant it. If both, grant !last. On grant: sel <= winner, last <= winner, count <= 0, next state BUSY.
- BUSY: gnt(sel)=1 and mem_valid=1.
  - mem_ready=1: rdata <= mem_rdata (on write, rdata <= 0), err <= 0, next state RESP.
  - mem_ready=0 and count==TIMEOUT-1: rdata <= 0, err <= 1, next state RESP.
  - Otherwise count <= count+1.
- RESP: done(sel)=1 for exactly this cycle; gnt(sel) stays 1, mem_valid=0; next state IDLE unconditionally. Requests are not sampled in RESP.
- Datapath muxing:
  - mem_addr = sel ? addr1 : addr0; mem_wdata likewise.
  - mem_we = mem_valid & (sel ? we1 : we0).
  - Muxing is combinational from sel. sel is registered and changes only on the IDLE->BUSY transition.
- The count register is 8 bits wide and compared against TIMEOUT-1; it never wraps.
- Reset (rst_n=0 at an edge): state=IDLE, sel=0, last=1 (so requester 0 wins the first tie), count=0, rdata=0, err=0. All gnt, done and mem_valid outputs are 0.
- Reset aborts any in-flight access. No done pulse is issued for the aborted access.

## Timing
- Grant latency: req high in IDLE at edge k gives BUSY from k+1; gnt, mem_valid and the new sel are visible in cycle k+1.
- Minimum access: mem_ready in the first BUSY cycle gives RESP (done) in cycle k+2 and IDLE in k+3. Total is 3 cycles per access.
- Maximum access: TIMEOUT BUSY cycles, then RESP with err=1.
- mem_ready and the timeout condition in the same cycle: mem_ready wins (err=0, data captured).
- A req held high through RESP is treated as a new request in the following IDLE cycle. Back-to-back throughput is 1 access per 3 cycles minimum.
- A req dropped during BUSY is ignored: the access completes and done still pulses.
- Requesters drop req in or after the done cycle to avoid a repeat access.
- done0 and done1 are never high together; gnt0 and gnt1 are never high together.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles with random inputs -> gnt0/1, done0/1, mem_valid, err, sel all 0; rdata = 0x00000000.
- **Single read:**
  - Stimulus: req0=1, addr0=0x00000040, we0=0; mem_ready=1 on the 3rd BUSY cycle with mem_rdata=0xDEADBEEF.
  - Required: sel=0 and mem_addr=0x00000040 during BUSY; done0 one cycle; rdata=0xDEADBEEF; err=0.
- **Tie after reset:**
  - Stimulus: req0=req1=1 together; requester 1 has we1=1, addr1=0x00000100, wdata1=0x12345678; mem_ready=1 immediately.
  - Required: requester 0 is served first (sel=0). Requester 0 drops req on done0. Then sel=1, mem_we=1, mem_addr=0x00000100, mem_wdata=0x12345678; done1 follows; rdata=0.
- **Fairness:** both reqs held high for 6 accesses with immediate mem_ready -> grant order 0,1,0,1,0,1; done pulses exactly 3 cycles apart.
- **Timeout:** req1=1, mem_ready held 0 -> mem_valid high for exactly 15 cycles, then done1 with err=1 and rdata=0. A subsequent access with mem_ready returns err=0.
- **Reset mid-access:** assert rst_n=0 for one cycle during the 2nd BUSY cycle -> next cycle is IDLE with mem_valid=0, no done pulse. A following tie grants requester 0.
